// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution layer sequencer.
package conv_pkg;

  // Sequencer states; M0 -> CN -> KRN repeats per kernel, DONE is a one-cycle exit.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    CN   = 3'd2,
    KRN  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam int WDT_CYCLES_DEFAULT = 1024;
  localparam int CNT_WIDTH_DEFAULT  = 8;
  localparam int K_PARAMS_DEFAULT   = 16;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Bundle between the layer controller (master) and the sequencer (slave).
//
// Signalling: there is no valid/ready pair. i_start is a level sampled on the
// clock edge and is honoured only when the sequencer is idle (o_busy=0);
// i_stall=1 means "downstream not ready" and freezes the sequencer for that
// cycle, forcing every phase enable low. A phase enable high at an edge means
// the address generator consumed that phase step on that edge.
interface conv_seq_ctrl_if
  import conv_pkg::*;
#(
  parameter int K_PARAMS  = K_PARAMS_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
);
  logic                 i_start;
  logic                 i_abort;
  logic                 i_stall;
  logic [CNT_WIDTH-1:0] i_n_channels;
  logic [CNT_WIDTH-1:0] i_n_kernels;
  logic                 i_end_kernel;
  logic [K_PARAMS-1:0]  i_w;
  logic                 o_enb_M0;
  logic                 o_enb_CN;
  logic                 o_enb_K;
  logic [CNT_WIDTH-1:0] o_kernel_idx;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [K_PARAMS-1:0]  o_w;

  modport master (
    output i_start, i_abort, i_stall, i_n_channels, i_n_kernels, i_end_kernel, i_w,
    input  o_enb_M0, o_enb_CN, o_enb_K, o_kernel_idx, o_busy, o_done, o_err, o_w
  );

  modport slave (
    input  i_start, i_abort, i_stall, i_n_channels, i_n_kernels, i_end_kernel, i_w,
    output o_enb_M0, o_enb_CN, o_enb_K, o_kernel_idx, o_busy, o_done, o_err, o_w
  );
endinterface

// File: rtl/conv_wdt.sv
// Per-kernel watchdog: counts K-phase enables and flags the last allowed one.
module conv_wdt
  import conv_pkg::*;
#(
  parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic limit
);
  localparam int W = cnt_bits(WDT_CYCLES);
  localparam logic [W-1:0] ONE_W   = W'(1);
  localparam logic [W-1:0] LAST_W  = W'(WDT_CYCLES - 1);

  logic [W-1:0] cnt_d, cnt_q;

  // Clear wins over increment so a new kernel always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE_W;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the current enable would be the WDT_CYCLES-th of this kernel.
  assign limit = (cnt_q == LAST_W);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer: walks M0 -> CN -> K for each kernel, counts kernels,
// reports done or a sticky watchdog error.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int K_PARAMS   = K_PARAMS_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  conv_seq_ctrl_if.slave   bus,
  output seq_state_t       o_dbg_state
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  seq_state_t           state_d, state_q;
  logic [CNT_WIDTH-1:0] n_ch_d, n_ch_q;
  logic [CNT_WIDTH-1:0] n_k_d, n_k_q;
  logic [CNT_WIDTH-1:0] ch_cnt_d, ch_cnt_q;
  logic [CNT_WIDTH-1:0] idx_d, idx_q;
  logic                 err_d, err_q;
  logic                 active;
  logic                 wdt_clr, wdt_inc, wdt_limit;
  logic [K_PARAMS-1:0]  w_pass;

  // A stalled cycle is a frozen cycle: no enable, no progress.
  assign active = !bus.i_stall;

  // Enables decode only the registered state and the stall, never the end flag.
  assign bus.o_enb_M0     = (state_q == M0)  && active;
  assign bus.o_enb_CN     = (state_q == CN)  && active;
  assign bus.o_enb_K      = (state_q == KRN) && active;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_done       = (state_q == DONE);
  assign bus.o_err        = err_q;
  assign bus.o_kernel_idx = idx_q;
  assign o_dbg_state      = state_q;

  // Kernel-geometry word goes straight through to the address generator.
  assign w_pass  = bus.i_w;
  assign bus.o_w = w_pass;

  // Next-state and counter update; abort overrides everything except reset.
  always_comb begin
    state_d  = state_q;
    n_ch_d   = n_ch_q;
    n_k_d    = n_k_q;
    ch_cnt_d = ch_cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wdt_clr  = 1'b0;
    wdt_inc  = 1'b0;
    if (bus.i_abort) begin
      state_d  = IDLE;
      ch_cnt_d = '0;
      idx_d    = '0;
      wdt_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            n_ch_d   = bus.i_n_channels;
            n_k_d    = bus.i_n_kernels;
            err_d    = 1'b0;
            idx_d    = '0;
            ch_cnt_d = '0;
            wdt_clr  = 1'b1;
            state_d  = (bus.i_n_kernels == '0) ? DONE : M0;
          end
        end
        M0: begin
          if (active) begin
            state_d = (n_ch_q == '0) ? KRN : CN;
          end
        end
        CN: begin
          if (active) begin
            if (ch_cnt_q == n_ch_q - CNT_ONE) begin
              ch_cnt_d = '0;
              state_d  = KRN;
            end else begin
              ch_cnt_d = ch_cnt_q + CNT_ONE;
            end
          end
        end
        KRN: begin
          if (active) begin
            if (bus.i_end_kernel) begin
              // End flag beats a simultaneous watchdog limit.
              wdt_clr = 1'b1;
              if (idx_q == n_k_q - CNT_ONE) begin
                state_d = DONE;
              end else begin
                idx_d   = idx_q + CNT_ONE;
                state_d = M0;
              end
            end else if (wdt_limit) begin
              wdt_clr = 1'b1;
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              wdt_inc = 1'b1;
            end
          end
        end
        DONE: begin
          // Not stall-gated so the done pulse is always exactly one cycle.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_ch_q   <= '0;
      n_k_q    <= '0;
      ch_cnt_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_ch_q   <= n_ch_d;
      n_k_q    <= n_k_d;
      ch_cnt_q <= ch_cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  conv_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wdt_clr),
    .inc   (wdt_inc),
    .limit (wdt_limit)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed vector table, hand sequences for abort and
// reset, and randomized layers checked against a phase-list model.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int CNT_W = 8;
  localparam int KP    = 16;
  localparam int WDT   = 8;
  localparam int QW    = 11;  // {is_end, kernel idx[7:0], phase[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.K_PARAMS(KP), .CNT_WIDTH(CNT_W)) bus ();
  seq_state_t dbg_state;

  conv_seq_ctrl #(
    .K_PARAMS  (KP),
    .CNT_WIDTH (CNT_W),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [QW-1:0] exp_q[$];
  int  end_at[16];
  bit  exp_err_sticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] ph_onehot(input logic [1:0] p);
    case (p)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] enbs();
    return {bus.o_enb_M0, bus.o_enb_CN, bus.o_enb_K};
  endfunction

  // Expected list of enabled steps for a whole layer: per kernel one M0, nch CN,
  // then K steps until the end flag, or WDT steps and an error if it never comes.
  task automatic build_model(input int nch, input int nk, output bit will_err);
    logic [7:0] kb;
    int e, nks;
    exp_q.delete();
    will_err = 1'b0;
    for (int k = 0; k < nk; k++) begin
      kb = k[7:0];
      exp_q.push_back({1'b0, kb, 2'd1});
      for (int c = 0; c < nch; c++) exp_q.push_back({1'b0, kb, 2'd2});
      e   = end_at[k];
      nks = (e < WDT) ? e : WDT;
      for (int j = 1; j <= nks; j++) exp_q.push_back({(j == e), kb, 2'd3});
      if (e > WDT) begin
        will_err = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_stall      = 1'b0;
    bus.i_end_kernel = 1'b0;
  endtask

  task automatic start_layer(input int nch, input int nk);
    bus.i_start      = 1'b1;
    bus.i_n_channels = nch[CNT_W-1:0];
    bus.i_n_kernels  = nk[CNT_W-1:0];
    bus.i_stall      = 1'b0;
    bus.i_end_kernel = 1'($urandom_range(1));
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Runs one layer from a negedge; returns the cycle (after start) of done/err.
  task automatic run_layer(input int nch, input int nk, input logic [63:0] stall_mask,
                           input int stall_pct, output int done_cycle, output bit got_err);
    bit will_err, st;
    logic [QW-1:0] it;
    int cyc;
    build_model(nch, nk, will_err);
    chk("err_before_start", 32'(bus.o_err), 32'(exp_err_sticky));
    start_layer(nch, nk);
    cyc = 1;
    chk("err_cleared_by_start", 32'(bus.o_err), 32'd0);
    exp_err_sticky = 1'b0;
    while (exp_q.size() > 0) begin
      st = ((cyc < 64) ? stall_mask[cyc[5:0]] : 1'b0) || ($urandom_range(99) < stall_pct);
      bus.i_stall = st;
      if (st) begin
        bus.i_end_kernel = 1'($urandom_range(1));
      end else begin
        it = exp_q[0];
        bus.i_end_kernel = (it[1:0] == 2'd3) ? it[10] : 1'($urandom_range(1));
      end
      #1;
      if (st) begin
        chk("enables_stalled", 32'(enbs()), 32'd0);
        chk("busy_stalled", 32'(bus.o_busy), 32'd1);
      end else begin
        it = exp_q.pop_front();
        chk("enables", 32'(enbs()), 32'(ph_onehot(it[1:0])));
        chk("kernel_idx", 32'(bus.o_kernel_idx), 32'(it[9:2]));
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_stall      = 1'b0;
    bus.i_end_kernel = 1'b0;
    #1;
    if (will_err) begin
      chk("err_set", 32'(bus.o_err), 32'd1);
      chk("busy_after_err", 32'(bus.o_busy), 32'd0);
      chk("no_done_on_err", 32'(bus.o_done), 32'd0);
      exp_err_sticky = 1'b1;
    end else begin
      chk("done_pulse", 32'(bus.o_done), 32'd1);
      chk("busy_in_done", 32'(bus.o_busy), 32'd1);
      chk("enables_in_done", 32'(enbs()), 32'd0);
    end
    done_cycle = cyc;
    got_err    = bus.o_err;
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.o_done), 32'd0);
    chk("idle_after_layer", 32'(bus.o_busy), 32'd0);
    if (nk > 0 && !will_err) chk("idx_holds_last", 32'(bus.o_kernel_idx), 32'(nk - 1));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          nch;
    int          nk;
    int          e;
    logic [63:0] mask;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    bit ge;
    int nch, nk;

    vecs[0] = '{nch: 3, nk: 2, e: 4, mask: 64'h0,  exp_cyc: 17, exp_err: 1'b0};
    vecs[1] = '{nch: 5, nk: 0, e: 1, mask: 64'h0,  exp_cyc: 1,  exp_err: 1'b0};
    vecs[2] = '{nch: 2, nk: 1, e: 1, mask: 64'h38, exp_cyc: 8,  exp_err: 1'b0};
    vecs[3] = '{nch: 1, nk: 1, e: 9, mask: 64'h0,  exp_cyc: 11, exp_err: 1'b1};
    vecs[4] = '{nch: 2, nk: 2, e: 3, mask: 64'h0,  exp_cyc: 13, exp_err: 1'b0};
    vecs[5] = '{nch: 0, nk: 3, e: 2, mask: 64'h0,  exp_cyc: 10, exp_err: 1'b0};
    vecs[6] = '{nch: 1, nk: 1, e: 8, mask: 64'h0,  exp_cyc: 11, exp_err: 1'b0};

    // Reset state.
    idle_inputs();
    bus.i_n_channels = '0;
    bus.i_n_kernels  = '0;
    bus.i_w          = 16'hA5C3;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_idx", 32'(bus.o_kernel_idx), 32'd0);
    chk("rst_enables", 32'(enbs()), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("w_passthrough", 32'(bus.o_w), 32'h0000A5C3);

    // Table-driven layers.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 16; k++) end_at[k] = vecs[i].e;
      run_layer(vecs[i].nch, vecs[i].nk, vecs[i].mask, 0, dc, ge);
      chk($sformatf("vec%0d_cycle", i), 32'(dc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].exp_err));
      if (i == 3) begin
        // Abort while idle must leave the sticky error alone.
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("err_kept_by_abort", 32'(bus.o_err), 32'd1);
      end
    end

    // Abort during K of kernel 1 of 3, with a start in the same cycle.
    start_layer(1, 3);
    for (int c = 1; c <= 6; c++) begin
      bus.i_end_kernel = (c == 4);
      @(negedge clk);
    end
    bus.i_end_kernel = 1'b0;
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    #1;
    chk("abort_pre_enb_k", 32'(enbs()), 32'(3'b001));
    chk("abort_pre_idx", 32'(bus.o_kernel_idx), 32'd1);
    @(negedge clk);
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    chk("abort_idx", 32'(bus.o_kernel_idx), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    chk("abort_start_ignored", 32'(bus.o_busy), 32'd0);
    chk("abort_err_unchanged", 32'(bus.o_err), 32'd0);

    // Reset in the middle of CN.
    start_layer(5, 2);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_cn", 32'(enbs()), 32'(3'b010));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.o_busy), 32'd0);
    chk("midrst_idx", 32'(bus.o_kernel_idx), 32'd0);
    chk("midrst_err", 32'(bus.o_err), 32'd0);
    chk("midrst_done", 32'(bus.o_done), 32'd0);
    chk("midrst_enables", 32'(enbs()), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    exp_err_sticky = 1'b0;
    end_at[0] = 1;
    run_layer(1, 1, 64'h0, 0, dc, ge);
    chk("after_rst_cycle", 32'(dc), 32'd4);

    // Randomized layers with random stalls and noise on the end flag.
    for (int r = 0; r < 40; r++) begin
      nch = $urandom_range(0, 4);
      nk  = $urandom_range(0, 4);
      for (int k = 0; k < 16; k++) end_at[k] = $urandom_range(1, 9);
      bus.i_w = 16'($urandom);
      run_layer(nch, nk, 64'h0, 25, dc, ge);
      chk("rand_w_passthrough", 32'(bus.o_w), 32'(bus.i_w));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
